upstream_risk_gate: RTL

Parametrised per-client pre-trade risk gate for the upstream path. Holds a per-client table of trade limit and net open exposure and serialises order, cancel and set-limit requests through a valid/ready handshake. Each request is checked against the client's limit and written back, and the gate returns an accept/reject verdict with a reason code. It generalises the single-client upstream check with:
- configurable client count and amount width,
- a halt input,
- self-initialising table storage,
- accept/reject statistics counters.

---
 rtl/upstream_risk_gate.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/upstream_risk_gate.sv
// ---------------------------------------------------------------------------
// upstream_risk_gate
//
// Per-client pre-trade risk gate. A table holds {limit, exposure} for every
// client. Requests (order / cancel / set-limit) are taken one at a time over
// a valid/ready handshake. Each request is checked against the client's
// entry and written back. The gate then returns an accept/reject verdict
// with a reason code.
//
// State | Meaning
// ------+------------------------------------------------------------------
// INIT  | sweep the table, one entry per cycle, to {DEFAULT_MAX, 0}
// IDLE  | req_ready high, waiting for a request
// READ  | synchronous table read of the latched client
// EXEC  | table data valid: decide the verdict, write back, latch response
// RESP  | rsp_valid high, fields held until rsp_ready; count the verdict
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   halt            blocks orders (cancel / set-limit unaffected)
//   req_*           request channel (valid/ready, client, op, amount)
//   rsp_*           verdict channel (valid/ready, accept, reason, exposure)
//   limit_updated   one-cycle pulse on entering RESP after a set-limit
//   init_done       table sweep finished
//   accept_cnt,
//   reject_cnt      saturating verdict counters
// ---------------------------------------------------------------------------
module upstream_risk_gate #(
    parameter int                CLIENT_W    = 10,
    parameter int                AMT_W       = 16,
    parameter logic [AMT_W-1:0]  DEFAULT_MAX = 16'd1000,
    parameter int                CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CLIENT_W-1:0] req_client,
    input  logic [1:0]          req_op,
    input  logic [AMT_W-1:0]    req_amount,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_accept,
    output logic [1:0]          rsp_reason,
    output logic [AMT_W-1:0]    rsp_exposure,
    output logic                limit_updated,
    output logic                init_done,
    output logic [CNT_W-1:0]    accept_cnt,
    output logic [CNT_W-1:0]    reject_cnt
);

    localparam int NUM_CLIENTS = 2 ** CLIENT_W;

    localparam logic [1:0] OP_ORDER  = 2'b00;
    localparam logic [1:0] OP_CANCEL = 2'b01;
    localparam logic [1:0] OP_SETLIM = 2'b10;

    localparam logic [1:0] RSN_OK    = 2'd0;
    localparam logic [1:0] RSN_LIMIT = 2'd1;
    localparam logic [1:0] RSN_BADOP = 2'd2;
    localparam logic [1:0] RSN_HALT  = 2'd3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_EXEC,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [CLIENT_W-1:0]   r_init_idx;
    logic [CLIENT_W-1:0]   r_client;
    logic [1:0]            r_op;
    logic [AMT_W-1:0]      r_amount;

    logic [AMT_W-1:0]      r_mem_limit [NUM_CLIENTS];
    logic [AMT_W-1:0]      r_mem_exp   [NUM_CLIENTS];
    logic [AMT_W-1:0]      r_rd_limit;
    logic [AMT_W-1:0]      r_rd_exp;

    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_accept;
    logic [1:0]            r_rsp_reason;
    logic [AMT_W-1:0]      r_rsp_exposure;
    logic                  r_limit_updated;
    logic                  r_init_done;
    logic [CNT_W-1:0]      r_accept_cnt;
    logic [CNT_W-1:0]      r_reject_cnt;

    logic [AMT_W:0]        w_sum;
    logic                  w_accept;
    logic [1:0]            w_reason;
    logic [AMT_W-1:0]      w_new_exp;
    logic [AMT_W-1:0]      w_new_limit;
    logic                  w_exec_we;
    logic                  w_we;
    logic [CLIENT_W-1:0]   w_waddr;
    logic [AMT_W-1:0]      w_wlimit;
    logic [AMT_W-1:0]      w_wexp;

    // Verdict for the request in EXEC, from the entry read in READ.
    always_comb begin
        // One extra bit so exposure + amount cannot wrap before the compare.
        w_sum       = {1'b0, r_rd_exp} + {1'b0, r_amount};
        w_accept    = 1'b0;
        w_reason    = RSN_OK;
        w_new_exp   = r_rd_exp;
        w_new_limit = r_rd_limit;
        w_exec_we   = 1'b0;
        case (r_op)
            OP_ORDER: begin
                if (halt) begin
                    w_reason = RSN_HALT;
                end else if (w_sum < {1'b0, r_rd_limit}) begin
                    w_accept  = 1'b1;
                    w_new_exp = w_sum[AMT_W-1:0];
                    w_exec_we = 1'b1;
                end else begin
                    w_reason = RSN_LIMIT;
                end
            end
            OP_CANCEL: begin
                w_accept  = 1'b1;
                w_new_exp = (r_rd_exp > r_amount) ? (r_rd_exp - r_amount) : '0;
                w_exec_we = 1'b1;
            end
            OP_SETLIM: begin
                w_accept    = 1'b1;
                w_new_limit = r_amount;
                w_exec_we   = 1'b1;
            end
            default: begin
                w_reason = RSN_BADOP;
            end
        endcase
    end

    // Single write port shared by the init sweep and the EXEC write-back.
    always_comb begin
        w_we     = 1'b0;
        w_waddr  = r_client;
        w_wlimit = w_new_limit;
        w_wexp   = w_new_exp;
        if (r_state == S_INIT) begin
            w_we     = 1'b1;
            w_waddr  = r_init_idx;
            w_wlimit = DEFAULT_MAX;
            w_wexp   = '0;
        end else if (r_state == S_EXEC) begin
            w_we = w_exec_we;
        end
        // A reset landing on EXEC must not commit the aborted request.
        if (rst) begin
            w_we = 1'b0;
        end
    end

    // Table storage: no reset, it is initialised by the INIT sweep.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_limit[w_waddr] <= w_wlimit;
            r_mem_exp[w_waddr]   <= w_wexp;
        end
        if (r_state == S_READ) begin
            r_rd_limit <= r_mem_limit[r_client];
            r_rd_exp   <= r_mem_exp[r_client];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_INIT;
            r_init_idx      <= '0;
            r_client        <= '0;
            r_op            <= '0;
            r_amount        <= '0;
            r_req_ready     <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_accept    <= 1'b0;
            r_rsp_reason    <= RSN_OK;
            r_rsp_exposure  <= '0;
            r_limit_updated <= 1'b0;
            r_init_done     <= 1'b0;
            r_accept_cnt    <= '0;
            r_reject_cnt    <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_idx == {CLIENT_W{1'b1}}) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_init_idx <= r_init_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_client    <= req_client;
                        r_op        <= req_op;
                        r_amount    <= req_amount;
                        r_req_ready <= 1'b0;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_rsp_valid     <= 1'b1;
                    r_rsp_accept    <= w_accept;
                    r_rsp_reason    <= w_reason;
                    r_rsp_exposure  <= w_new_exp;
                    r_limit_updated <= (r_op == OP_SETLIM);
                    r_state         <= S_RESP;
                end
                S_RESP: begin
                    r_limit_updated <= 1'b0;
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_rsp_accept) begin
                            if (r_accept_cnt != {CNT_W{1'b1}}) begin
                                r_accept_cnt <= r_accept_cnt + 1'b1;
                            end
                        end else begin
                            if (r_reject_cnt != {CNT_W{1'b1}}) begin
                                r_reject_cnt <= r_reject_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_accept    = r_rsp_accept;
    assign rsp_reason    = r_rsp_reason;
    assign rsp_exposure  = r_rsp_exposure;
    assign limit_updated = r_limit_updated;
    assign init_done     = r_init_done;
    assign accept_cnt    = r_accept_cnt;
    assign reject_cnt    = r_reject_cnt;

endmodule
